wav_stream_parser: RTL and testbench
====================================

// Module: wav_stream_parser
// PURPOSE
//  Consumes a byte stream of a PCM WAV file (44-byte canonical header, then data) and produces signed 16-bit samples.
//  Validates and exposes header fields; the inverse of the bench-side WAV writer. Sits between a byte source (file/DMA) and audio DSP.
// PARAMETERS
//  CHECK_BYTE_RATE  1   1: byte_rate must equal sample_rate*bits_per_sample/8, else error 5
//  CNT_W            32  width of data byte counter (data_size field)
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   async active-low reset
//  restart          in   1   sync pulse: abort, return to HDR, clear fields/flags (wins over all other inputs)
//  in_data          in   8   input byte
//  in_valid         in   1   byte valid
//  in_ready         out  1   byte accepted when in_valid&in_ready
//  out_sample       out  16  signed PCM sample
//  out_valid        out  1   sample valid, held until out_ready
//  out_ready        in   1   downstream accept
//  out_last         out  1   with out_valid: final sample of data chunk
//  sample_rate      out  32  header offset 24..27
//  bits_per_sample  out  16  header offset 34..35
//  data_bytes       out  CNT_W header offset 40..43
//  hdr_valid        out  1   level: header parsed OK
//  hdr_err          out  1   level: header rejected
//  err_code         out  3   cause, valid while hdr_err
//  done             out  1   level: all data bytes consumed
// BEHAVIOUR
//  Reset (rst_n=0 or restart): state=HDR, byte_idx=0, all outputs 0; in_ready=1 after reset release.
//  Multi-byte fields are little-endian; tags are ASCII in order "RIFF"@0, "WAVE"@8, "fmt "@12, "data"@36.
//  HDR: in_ready=1; byte_idx 0..43 increments per accepted byte; each field checked when its last byte is accepted:
//   1 RIFF tag; 2 WAVE tag; 3 "fmt " tag or fmt length(16..19)!=16; 4 fmt_type!=1, channels!=1 or bps not 8/16;
//   5 byte_rate mismatch (if CHECK_BYTE_RATE); 6 "data" tag. Bytes 4..7 (riff size) and 32..33 (block align) ignored.
//   First failure -> ERR next cycle, err_code latched, first error only.
//  Byte 43 accepted OK: hdr_valid=1 and fields stable next cycle; state=DATA with remaining=data_bytes; if data_bytes==0 -> DONE directly.
//  DATA: in_ready = !out_valid | out_ready (single output register, no skid).
//   bps=16: low byte held, high byte completes sample {hi,lo}; bps=8: each byte -> {byte^8'h80, 8'h00} (unsigned->signed).
//   out_valid rises the cycle after the completing byte is accepted; out_last=1 when remaining reaches 0 with that byte.
//   remaining decrements per accepted byte; at 0 -> DONE. bps=16 with odd data_bytes: trailing byte dropped, no sample, last sample already carried out_last? no: done without out_last on a partial; previous complete sample has out_last=0.
//   Simultaneous out_ready and accepted completing byte: old sample leaves, new loaded same edge.
//  DONE: done=1, in_ready=0, pending sample still drains via out_ready; stays until restart/reset.
//  ERR: hdr_err=1, hdr_valid=0, in_ready=1 and bytes discarded (stream flushed), out_valid=0, until restart/reset.
//  Async reset mid-DATA: pending sample discarded, out_valid drops immediately.
// TESTING
//  1 Header fs=12500,ch=1,bps=16,byte_rate=25000,data=4; bytes 34 12 CD AB -> samples 0x1234, 0xABCD(out_last), hdr_valid, done.
//  2 bps=8, byte_rate=12500, data=3; bytes 80 FF 00 -> 0x0000, 0x7F00, 0x8000(out_last), done.
//  3 Byte 8 = "X" instead of "W" -> hdr_err=1, err_code=2 cycle after byte 11; later bytes absorbed, no out_valid.
//  4 byte_rate=12500 with bps=16, CHECK_BYTE_RATE=1 -> err_code=5; channels=2 -> err_code=4.
//  5 out_ready=0 for 10 cycles with sample pending -> in_ready=0, out_sample stable; release -> no loss/duplication over 1000 random samples.
//  6 rst_n low after 2nd sample of 4 -> outputs 0 asynchronously; restart pulse mid-header -> re-parse fresh file correctly; data=0 -> done, no samples; bps=16 data=3 -> 1 sample, done.

Source files
------------

// File: rtl/wav_stream_parser.sv
// ---------------------------------------------------------------------------
// wav_stream_parser: canonical 44-byte PCM WAV header check + byte-to-sample unpacker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wav_stream_parser #(
  parameter int CHECK_BYTE_RATE = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      out_sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [31:0]      sample_rate,
  output logic [15:0]      bits_per_sample,
  output logic [CNT_W-1:0] data_bytes,
  output logic             hdr_valid,
  output logic             hdr_err,
  output logic [2:0]       err_code,
  output logic             done
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [31:0] c_TAG_RIFF = 32'h4646_4952;
  localparam logic [31:0] c_TAG_WAVE = 32'h4556_4157;
  localparam logic [31:0] c_TAG_FMT  = 32'h2074_6d66;
  localparam logic [31:0] c_TAG_DATA = 32'h6174_6164;

  state_t           r_state, w_next;
  logic             r_live;
  logic [5:0]       r_idx;
  logic [23:0]      r_word;
  logic [31:0]      w_word;
  logic [31:0]      r_sr, r_br;
  logic [15:0]      r_bps;
  logic [CNT_W-1:0] r_data_bytes, r_rem;
  logic             r_hdr_valid;
  logic [2:0]       r_err_code, w_err;
  logic             r_phase;
  logic [7:0]       r_lo;
  logic [15:0]      r_out_sample;
  logic             r_out_valid, r_out_last;
  logic             w_rdy, w_acc, w_bps8;
  logic [32:0]      w_br_exp;

  // Little-endian field assembly: the incoming byte is always the MSB of the window
  assign w_word   = {in_data, r_word};
  assign w_bps8   = (r_bps == 16'd8);
  assign w_br_exp = (w_word[31:16] == 16'd16) ? {r_sr, 1'b0} : {1'b0, r_sr};
  assign w_acc    = in_valid & w_rdy & r_live;

  always_comb begin
    w_err = 3'd0;
    case (r_idx)
      6'd3:  if (w_word != c_TAG_RIFF) w_err = 3'd1;
      6'd11: if (w_word != c_TAG_WAVE) w_err = 3'd2;
      6'd15: if (w_word != c_TAG_FMT)  w_err = 3'd3;
      6'd19: if (w_word != 32'd16)     w_err = 3'd3;
      6'd21: if (w_word[31:16] != 16'd1) w_err = 3'd4;
      6'd23: if (w_word[31:16] != 16'd1) w_err = 3'd4;
      6'd35: begin
        if (w_word[31:16] != 16'd8 && w_word[31:16] != 16'd16) w_err = 3'd4;
        else if (CHECK_BYTE_RATE != 0 && w_br_exp != {1'b0, r_br}) w_err = 3'd5;
      end
      6'd39: if (w_word != c_TAG_DATA) w_err = 3'd6;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_rdy  = 1'b0;
    case (r_state)
      S_HDR: begin
        w_rdy = 1'b1;
        if (w_acc) begin
          if (w_err != 3'd0)
            w_next = S_ERR;
          else if (r_idx == 6'd43)
            w_next = (w_word[CNT_W-1:0] == '0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        w_rdy = !r_out_valid | out_ready;
        if (w_acc && r_rem == CNT_W'(1)) w_next = S_DONE;
      end
      S_ERR:   w_rdy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HDR;
      r_live  <= 1'b0;
    end else begin
      r_state <= restart ? S_HDR : w_next;
      r_live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || restart) begin
      r_idx        <= '0;
      r_word       <= '0;
      r_sr         <= '0;
      r_br         <= '0;
      r_bps        <= '0;
      r_data_bytes <= '0;
      r_rem        <= '0;
      r_hdr_valid  <= 1'b0;
      r_err_code   <= '0;
      r_phase      <= 1'b0;
      r_lo         <= '0;
      r_out_sample <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
    end else begin
      if (r_state == S_HDR && w_acc) begin
        r_idx  <= r_idx + 6'd1;
        r_word <= w_word[31:8];
        case (r_idx)
          6'd27: r_sr  <= w_word;
          6'd31: r_br  <= w_word;
          6'd35: r_bps <= w_word[31:16];
          6'd43: begin
            r_data_bytes <= w_word[CNT_W-1:0];
            r_rem        <= w_word[CNT_W-1:0];
          end
          default: ;
        endcase
        if (w_err != 3'd0)
          r_err_code <= w_err;
        else if (r_idx == 6'd43)
          r_hdr_valid <= 1'b1;
      end
      if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      // A completing byte overrides the drain above so hand-off and reload share one edge
      if (r_state == S_DATA && w_acc) begin
        r_rem <= r_rem - CNT_W'(1);
        if (w_bps8) begin
          r_out_sample <= {in_data ^ 8'h80, 8'h00};
          r_out_valid  <= 1'b1;
          r_out_last   <= (r_rem == CNT_W'(1));
        end else if (!r_phase) begin
          r_lo    <= in_data;
          r_phase <= 1'b1;
        end else begin
          r_out_sample <= {in_data, r_lo};
          r_out_valid  <= 1'b1;
          r_out_last   <= (r_rem == CNT_W'(1));
          r_phase      <= 1'b0;
        end
      end
    end
  end

  assign in_ready        = w_rdy & r_live;
  assign out_sample      = r_out_sample;
  assign out_valid       = r_out_valid;
  assign out_last        = r_out_last;
  assign sample_rate     = r_sr;
  assign bits_per_sample = r_bps;
  assign data_bytes      = r_data_bytes;
  assign hdr_valid       = r_hdr_valid;
  assign hdr_err         = (r_state == S_ERR);
  assign err_code        = r_err_code;
  assign done            = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_wav_stream_parser.sv
// ---------------------------------------------------------------------------
// tb_wav_stream_parser: builds WAV byte streams and checks parser against a byte-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wav_stream_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [31:0] sample_rate;
  logic [15:0] bits_per_sample;
  logic [31:0] data_bytes;
  logic        hdr_valid, hdr_err, done;
  logic [2:0]  err_code;

  wav_stream_parser #(.CHECK_BYTE_RATE(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .sample_rate(sample_rate), .bits_per_sample(bits_per_sample), .data_bytes(data_bytes),
    .hdr_valid(hdr_valid), .hdr_err(hdr_err), .err_code(err_code), .done(done)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          tmo     = 0;
  int          ready_mode = 1;  // 0: hold low, 1: always high, 2: random
  logic [7:0]  hdr [44];
  logic [7:0]  dat [$];
  logic [15:0] got_s [$];
  bit          got_l [$];
  logic [15:0] exp_s [$];
  bit          exp_l [$];

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Handshake values are stable at the falling edge ahead of the accepting rising edge
  always @(negedge clk)
    if (rst_n && !restart && out_valid && out_ready) begin
      got_s.push_back(out_sample);
      got_l.push_back(out_last);
    end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic put_le(input int off, input logic [31:0] v, input int n);
    for (int k = 0; k < n; k++) hdr[off + k] = v[8*k +: 8];
  endtask

  task automatic put_tag(input int off, input string t);
    for (int k = 0; k < 4; k++) hdr[off + k] = t[k];
  endtask

  task automatic build_hdr(input logic [31:0] sr, input logic [15:0] ch, input logic [15:0] bps,
                           input logic [31:0] br, input logic [31:0] db);
    put_tag(0, "RIFF"); put_le(4, db + 32'd36, 4); put_tag(8, "WAVE"); put_tag(12, "fmt ");
    put_le(16, 32'd16, 4); put_le(20, 32'd1, 2); put_le(22, {16'd0, ch}, 2);
    put_le(24, sr, 4); put_le(28, br, 4); put_le(32, {16'd0, ch} * {16'd0, bps} / 8, 2);
    put_le(34, {16'd0, bps}, 2); put_tag(36, "data"); put_le(40, db, 4);
  endtask

  // Expected samples straight from the file format: whole samples only, last flagged if the chunk ends on it
  task automatic build_expect(input int bps);
    int bpsmp;
    exp_s.delete(); exp_l.delete();
    bpsmp = bps / 8;
    for (int i = 0; i + bpsmp <= dat.size(); i += bpsmp) begin
      if (bpsmp == 1) exp_s.push_back({dat[i] ^ 8'h80, 8'h00});
      else            exp_s.push_back({dat[i+1], dat[i]});
      exp_l.push_back(i + bpsmp == dat.size());
    end
  endtask

  function automatic int q_diff();
    if (got_s.size() != exp_s.size()) return -2;
    foreach (exp_s[i]) if (got_s[i] !== exp_s[i] || got_l[i] !== exp_l[i]) return i;
    return -1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) tmo++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_hdr_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(hdr[i]);
  endtask

  task automatic send_data();
    foreach (dat[i]) send_byte(dat[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    got_s.delete(); got_l.delete(); tmo = 0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_last, out_sample, sample_rate, bits_per_sample, data_bytes,
         hdr_valid, hdr_err, err_code, done} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero output in_ready=%b valid=%b sample=%h, required all 0",
                         in_ready, out_valid, out_sample);
    end
    idle(2); rst_n = 1'b1; idle(2);
    n_tests++;
    if (in_ready !== 1'b1 || done !== 1'b0 || hdr_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: in_ready=%b done=%b hdr_err=%b, required 1 0 0", in_ready, done, hdr_err);
    end
  endtask

  task automatic test_pcm16();
    int d;
    ready_mode = 1; do_restart();
    build_hdr(12500, 1, 16, 25000, 4);
    send_hdr_range(0, 43);
    n_tests++;
    if (hdr_valid !== 1'b1 || hdr_err !== 1'b0 || sample_rate !== 32'd12500 ||
        bits_per_sample !== 16'd16 || data_bytes !== 32'd4) begin
      n_fail++; $display("FAIL pcm16_header: valid=%b err=%b fs=%0d bps=%0d db=%0d, required 1 0 12500 16 4",
                         hdr_valid, hdr_err, sample_rate, bits_per_sample, data_bytes);
    end
    dat = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    send_data(); idle(5); build_expect(16);
    d = q_diff();
    n_tests++;
    if (d != -1 || tmo != 0) begin
      n_fail++; $display("FAIL pcm16_samples: got %0d samples (diff %0d, tmo %0d), required %0d", got_s.size(), d, tmo, exp_s.size());
    end
    n_tests++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL pcm16_done: done=%b in_ready=%b, required 1 0", done, in_ready);
    end
  endtask

  task automatic test_tag_error();
    do_restart();
    build_hdr(12500, 1, 16, 25000, 4);
    hdr[8] = "X";
    send_hdr_range(0, 10);
    n_tests++;
    if (hdr_err !== 1'b0) begin
      n_fail++; $display("FAIL tag_err_early: hdr_err=%b before byte 11, required 0", hdr_err);
    end
    send_hdr_range(11, 11);
    n_tests++;
    if (hdr_err !== 1'b1 || err_code !== 3'd2) begin
      n_fail++; $display("FAIL tag_err_code: hdr_err=%b code=%0d, required 1 2", hdr_err, err_code);
    end
    send_hdr_range(12, 43);
    dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_data(); idle(3);
    n_tests++;
    if (tmo != 0 || got_s.size() != 0 || out_valid !== 1'b0 || hdr_valid !== 1'b0 || err_code !== 3'd2) begin
      n_fail++; $display("FAIL tag_err_flush: tmo=%0d samples=%0d valid=%b hv=%b code=%0d, required 0 0 0 0 2",
                         tmo, got_s.size(), out_valid, hdr_valid, err_code);
    end
  endtask

  task automatic test_hdr_errors();
    logic [2:0] exp_code [7] = '{3'd1, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6};
    for (int k = 0; k < 7; k++) begin
      do_restart();
      build_hdr(12500, 1, 16, 25000, 4);
      case (k)
        0: hdr[1] = "X";
        1: hdr[14] = "X";
        2: put_le(16, 32'd18, 4);
        3: put_le(22, 32'd2, 2);
        4: put_le(34, 32'd24, 2);
        5: put_le(28, 32'd12500, 4);
        default: hdr[39] = "A";
      endcase
      send_hdr_range(0, 43);
      n_tests++;
      if (hdr_err !== 1'b1 || err_code !== exp_code[k] || hdr_valid !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL hdr_err_case%0d: err=%b code=%0d hv=%b done=%b, required 1 %0d 0 0",
                           k, hdr_err, err_code, hdr_valid, done, exp_code[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d;
    logic [15:0] s0;
    bit hold_ok = 1'b1;
    do_restart();
    ready_mode = 0;
    dat.delete();
    for (int i = 0; i < 2000; i++) dat.push_back(8'($urandom));
    build_hdr(8000, 1, 16, 16000, 2000);
    idle(1);
    send_hdr_range(0, 43);
    send_byte(dat[0]); send_byte(dat[1]);
    s0 = out_sample;
    repeat (10) begin
      idle(1);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sample !== s0) hold_ok = 1'b0;
    end
    n_tests++;
    if (!hold_ok || s0 !== {dat[1], dat[0]}) begin
      n_fail++; $display("FAIL stall_hold: sample=%h in_ready=%b, required %h held with in_ready 0",
                         out_sample, in_ready, {dat[1], dat[0]});
    end
    ready_mode = 2;
    for (int i = 2; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      send_byte(dat[i]);
    end
    ready_mode = 1;
    idle(6); build_expect(16);
    d = q_diff();
    n_tests++;
    if (d != -1 || tmo != 0 || done !== 1'b1) begin
      n_fail++; $display("FAIL stream_1000: got %0d samples (diff %0d, tmo %0d, done %b), required %0d done 1",
                         got_s.size(), d, tmo, done, exp_s.size());
    end
  endtask

  task automatic test_async_reset();
    ready_mode = 1; do_restart();
    build_hdr(12500, 1, 16, 25000, 8);
    send_hdr_range(0, 43);
    dat = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_data();
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: out_valid=%b, required 1", out_valid);
    end
    rst_n = 1'b0; #1;
    n_tests++;
    if ({in_ready, out_valid, out_last, out_sample, sample_rate, bits_per_sample, data_bytes,
         hdr_valid, hdr_err, err_code, done} !== '0) begin
      n_fail++; $display("FAIL areset_clear: valid=%b sample=%h hv=%b fs=%0d, required all 0",
                         out_valid, out_sample, hdr_valid, sample_rate);
    end
    #13; rst_n = 1'b1; idle(2);
  endtask

  task automatic test_restart_pcm8();
    int d;
    ready_mode = 1; do_restart();
    build_hdr(12500, 1, 8, 12500, 3);
    send_hdr_range(0, 29);
    do_restart();
    n_tests++;
    if (sample_rate !== 32'd0 || hdr_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL restart_clear: fs=%0d hv=%b in_ready=%b, required 0 0 1", sample_rate, hdr_valid, in_ready);
    end
    send_hdr_range(0, 43);
    dat = '{8'h80, 8'hFF, 8'h00};
    send_data(); idle(5); build_expect(8);
    d = q_diff();
    n_tests++;
    if (d != -1 || tmo != 0 || done !== 1'b1 || bits_per_sample !== 16'd8) begin
      n_fail++; $display("FAIL pcm8_samples: got %0d samples (diff %0d, done %b, bps %0d), required %0d done 1 bps 8",
                         got_s.size(), d, done, bits_per_sample, exp_s.size());
    end
  endtask

  task automatic test_short_data();
    int d;
    do_restart();
    build_hdr(44100, 1, 16, 88200, 0);
    send_hdr_range(0, 43);
    n_tests++;
    if (done !== 1'b1 || hdr_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL zero_data: done=%b hv=%b in_ready=%b, required 1 1 0", done, hdr_valid, in_ready);
    end
    idle(4);
    n_tests++;
    if (got_s.size() != 0) begin
      n_fail++; $display("FAIL zero_data_samples: got %0d samples, required 0", got_s.size());
    end
    do_restart();
    build_hdr(44100, 1, 16, 88200, 3);
    send_hdr_range(0, 43);
    dat = '{8'($urandom), 8'($urandom), 8'($urandom)};
    send_data(); idle(5); build_expect(16);
    d = q_diff();
    n_tests++;
    if (d != -1 || tmo != 0 || done !== 1'b1) begin
      n_fail++; $display("FAIL odd16: got %0d samples (diff %0d, done %b), required %0d with out_last 0, done 1",
                         got_s.size(), d, done, exp_s.size());
    end
  endtask

  initial begin
    test_reset();
    test_pcm16();
    test_tag_error();
    test_hdr_errors();
    test_back_to_back();
    test_async_reset();
    test_restart_pcm8();
    test_short_data();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
